// File: rtl/pipelined_alu.sv
// pipelined_alu: WIDTH-bit ALU with valid/ready on both sides and a registered
// result/flag stage that holds its value until the consumer takes it.
// Optional iterative shift-add multiplier, compiled in when the macro
// PIPELINED_ALU_MUL_EN is defined; without it op 110 is reported as illegal.
module pipelined_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SLT  = 3'b100;
   localparam logic [2:0] OP_SLTU = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;

   // Reject parameter sets the counter cannot cover.
   if (WIDTH < 4 || (2 ** CNT_W) <= WIDTH) begin : g_param_check
      $error("pipelined_alu: WIDTH must be >= 4 and 2**CNT_W must exceed WIDTH");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             out_valid_q, out_valid_d;

   logic             accept;
   logic             is_sub;
   logic [WIDTH-1:0] b_op;
   logic             carry_seed;
   logic [WIDTH:0]   sum_full;
   logic             carry_out;
   logic             carry_into_msb;
   logic             add_ovf;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;
   logic             alu_ovf;
   logic             alu_illegal;
   logic             start_mul;

`ifdef PIPELINED_ALU_MUL_EN
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   assign in_ready  = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

   // Single-cycle ALU: one shared adder serves ADD, SUB and both compares.
   always_comb begin
      is_sub         = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
      b_op           = is_sub ? ~b : b;
      carry_seed     = is_sub ? 1'b1 : ((op == OP_ADD) ? cin : 1'b0);
      sum_full       = {1'b0, a} + {1'b0, b_op} + (WIDTH + 1)'(carry_seed);
      carry_out      = sum_full[WIDTH];
      carry_into_msb = a[WIDTH-1] ^ b_op[WIDTH-1] ^ sum_full[WIDTH-1];
      add_ovf        = carry_into_msb ^ carry_out;
      alu_result     = '0;
      alu_cout       = 1'b0;
      alu_ovf        = 1'b0;
      alu_illegal    = 1'b0;
      case (op)
         OP_AND:  alu_result = a & b;
         OP_OR:   alu_result = a | b;
         OP_ADD,
         OP_SUB: begin
            alu_result = sum_full[WIDTH-1:0];
            alu_cout   = carry_out;
            alu_ovf    = add_ovf;
         end
         OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, add_ovf ^ sum_full[WIDTH-1]};
         OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, ~carry_out};
         default: alu_illegal = 1'b1;
      endcase
`ifdef PIPELINED_ALU_MUL_EN
      start_mul = (op == OP_MUL);
`else
      start_mul = 1'b0;
`endif
   end

`ifdef PIPELINED_ALU_MUL_EN
   // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
   always_comb begin
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
   end
`endif

   // Next-state logic for the control FSM, output registers and multiplier datapath.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      cout_d      = cout_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = out_valid_q && !out_ready;
`ifdef PIPELINED_ALU_MUL_EN
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept && start_mul) begin
`ifdef PIPELINED_ALU_MUL_EN
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = ST_MUL;
`endif
            end else if (accept) begin
               result_d    = alu_result;
               cout_d      = alu_cout;
               overflow_d  = alu_ovf;
               zero_d      = (alu_result == '0);
               illegal_d   = alu_illegal;
               out_valid_d = 1'b1;
            end
         end
`ifdef PIPELINED_ALU_MUL_EN
         ST_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               result_d    = acc_step[WIDTH-1:0];
               cout_d      = 1'b0;
               overflow_d  = |acc_step[2*WIDTH-1:WIDTH];
               zero_d      = (acc_step[WIDTH-1:0] == '0);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State register with synchronous reset; a reset mid-multiply drops the partial product.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         cout_q      <= cout_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
`ifdef PIPELINED_ALU_MUL_EN
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu (WIDTH = 32). Expected results come from
// an arithmetic model, are queued when a request is accepted and compared when
// the consumer takes the result. MUL checks depend on PIPELINED_ALU_MUL_EN.
`timescale 1ns/1ps
module tb_pipelined_alu;

   localparam int WIDTH = 32;

   typedef struct packed {
      logic [31:0] result;
      logic        cout;
      logic        overflow;
      logic        zero;
      logic        illegal;
   } expT;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        cout;
   logic        overflow;
   logic        zero;
   logic        illegal;

   int  checks   = 0;
   int  failures = 0;
   expT expQ[$];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   pipelined_alu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero),
      .illegal   (illegal)
   );

   // Counts one comparison and reports it when the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic written from the opcode definitions.
   function automatic expT model(input logic [2:0] mop, input logic [31:0] ma,
                                 input logic [31:0] mb, input logic mcin);
      expT         e;
      logic [32:0] wide;
      logic [63:0] prod;
      e    = '0;
      wide = '0;
      prod = '0;
      case (mop)
         3'd0: e.result = ma & mb;
         3'd1: e.result = ma | mb;
         3'd2: begin
            wide       = {1'b0, ma} + {1'b0, mb} + {32'b0, mcin};
            e.result   = wide[31:0];
            e.cout     = wide[32];
            e.overflow = (ma[31] == mb[31]) && (wide[31] != ma[31]);
         end
         3'd3: begin
            e.result   = ma - mb;
            e.cout     = (ma >= mb);
            e.overflow = (ma[31] != mb[31]) && (e.result[31] != ma[31]);
         end
         3'd4: e.result = {31'b0, ($signed(ma) < $signed(mb))};
         3'd5: e.result = {31'b0, (ma < mb)};
`ifdef PIPELINED_ALU_MUL_EN
         3'd6: begin
            prod       = {32'b0, ma} * {32'b0, mb};
            e.result   = prod[31:0];
            e.overflow = (prod[63:32] != 32'b0);
         end
`endif
         default: e.illegal = 1'b1;
      endcase
      e.zero = (e.result == 32'b0);
      return e;
   endfunction

   // Drives one request, waits (bounded) for acceptance and queues its expected result.
   task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn,
                                input logic [31:0] bIn, input logic cinIn, input bit expectResult);
      bit accepted = 1'b0;
      op       = opIn;
      a        = aIn;
      b        = bIn;
      cin      = cinIn;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
            if (expectResult) expQ.push_back(model(opIn, aIn, bIn, cinIn));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("acceptTimeout", 64'd0, 64'd1);
   endtask

   // Waits (bounded) until every queued result has been consumed.
   task automatic waitDrain();
      for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput("drain", 64'(expQ.size()), 64'd0);
   endtask

   // Scoreboard: a result is taken when out_valid && out_ready at mid-cycle.
   always @(negedge clk) begin
      expT e;
      if (!rst && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedResult", 64'd1, 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("result", result, e.result);
            checkOutput("cout", cout, e.cout);
            checkOutput("overflow", overflow, e.overflow);
            checkOutput("zero", zero, e.zero);
            checkOutput("illegal", illegal, e.illegal);
         end
      end
   end

   // Main sequence.
   initial begin
      int latency;
      bit sawReady;
      bit sawValid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'd0;
      a         = 32'd0;
      b         = 32'd0;
      cin       = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rstInReady", in_ready, 0);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstResult", result, 0);
      checkOutput("rstCout", cout, 0);
      checkOutput("rstOverflow", overflow, 0);
      checkOutput("rstZero", zero, 0);
      checkOutput("rstIllegal", illegal, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("readyAfterReset", in_ready, 1);
      @(posedge clk);
      #1;

      // Directed single-cycle operations, back to back.
      applyStimulus(3'd2, 32'd40, 32'd10, 1'b0, 1'b1);
      checkOutput("addDirect", result, 32'd50);
      applyStimulus(3'd3, 32'd10, 32'd40, 1'b0, 1'b1);
      applyStimulus(3'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      applyStimulus(3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      applyStimulus(3'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1);
      applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
      applyStimulus(3'd3, 32'd1234, 32'd1234, 1'b1, 1'b1);
      applyStimulus(3'd4, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
      applyStimulus(3'd3, 32'h8000_0000, 32'd1, 1'b0, 1'b1);
      applyStimulus(3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b1);
      applyStimulus(3'd1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
      applyStimulus(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
      checkOutput("reservedDirect", illegal, 1);

      // Random operations (all opcodes, operands and carry-in).
      for (int i = 0; i < 12; i++) begin
         logic [2:0] rop;
         rop = 3'($urandom_range(0, 7));
         applyStimulus(rop, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end
      waitDrain();

      // Backpressure: result held, second request stalls until the consumer drains.
      out_ready = 1'b0;
      applyStimulus(3'd0, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1'b1);
      op       = 3'd1;
      a        = 32'd1;
      b        = 32'd2;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bpValid", out_valid, 1);
         checkOutput("bpResult", result, 32'h0000_00F0);
         checkOutput("bpReady", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bpReadyRaised", in_ready, 1);
      expQ.push_back(model(3'd1, 32'd1, 32'd2, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bpSecondValid", out_valid, 1);
      checkOutput("bpSecondResult", result, 32'd3);
      @(negedge clk);
      checkOutput("bpNoDuplicate", out_valid, 0);
      @(posedge clk);
      #1;
      waitDrain();

`ifdef PIPELINED_ALU_MUL_EN
      // Multiplier: exact latency, in_ready low throughout, operands ignored after accept.
      applyStimulus(3'd6, 32'd400, 32'd100, 1'b0, 1'b1);
      a        = $urandom;
      b        = $urandom;
      latency  = 0;
      sawReady = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            latency = n;
            break;
         end
         if (in_ready) sawReady = 1'b1;
      end
      checkOutput("mulLatency", 64'(latency), 64'(WIDTH));
      checkOutput("mulReadyLow", sawReady, 0);
      checkOutput("mulDirect", result, 32'd40000);
      applyStimulus(3'd6, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
      applyStimulus(3'd6, 32'hDEAD_BEEF, 32'h0000_1357, 1'b0, 1'b1);
      waitDrain();
`else
      // Without the multiplier op 110 is a one-cycle illegal operation.
      applyStimulus(3'd6, 32'd400, 32'd100, 1'b0, 1'b1);
      checkOutput("op6Latency", out_valid, 1);
      checkOutput("op6Illegal", illegal, 1);
      checkOutput("op6Result", result, 0);
      waitDrain();
`endif

      // Reset in the middle of an operation: nothing may be emitted afterwards.
`ifdef PIPELINED_ALU_MUL_EN
      applyStimulus(3'd6, 32'd123, 32'd456, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
`else
      applyStimulus(3'd6, 32'd123, 32'd456, 1'b0, 1'b1);
      @(posedge clk);
      #1;
`endif
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midRstReady", in_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("midRstValid", out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postRstReady", in_ready, 1);
      checkOutput("postRstValid", out_valid, 0);
      sawValid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("noResultAfterRst", sawValid, 0);
      @(posedge clk);
      #1;
      applyStimulus(3'd2, 32'd1, 32'd1, 1'b0, 1'b1);
      checkOutput("addAfterRst", result, 32'd2);
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, clocked successor to the combinational ripple ALU: a WIDTH-bit ALU with valid/ready handshakes on both sides, a registered result/flag stage, and an optional iterative shift-add multiplier. It sits between the register-file read stage and the write-back stage of the datapath. It replaces the free-running combinational `out`/`zero` path with a result held stable until the consumer takes it.

## Interface
- `WIDTH`, default 32: operand and result width (≥ 4).
- `CNT_W`, default 6: multiplier iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block accepts request this cycle.
- `op` in 3: opcode (see Operation).
- `a`, `b` in WIDTH: operands.
- `cin` in 1: carry-in, used by ADD only.
- `out_valid` out 1: result registers hold an unconsumed result.
- `out_ready` in 1: consumer takes result this cycle.
- `result` out WIDTH: registered result.
- `cout` out 1: registered carry-out.
- `overflow` out 1: registered overflow.
- `zero` out 1: registered, 1 when result == 0.
- `illegal` out 1: registered, 1 when the op was unsupported.

## Operation
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD: a+b+cin.
  - 011 SUB: a+~b+1, cin ignored.
  - 100 SLT signed: result = {0…, less}, where less = overflow(a−b) XOR sum[MSB].
  - 101 SLTU: result = {0…, ~cout(a−b)}.
  - 110 MUL: low WIDTH bits of unsigned a×b.
  - 111 reserved.
- Flags:
  - ADD/SUB: cout = carry out of MSB; overflow = carry into MSB XOR carry out of MSB.
  - AND, OR, SLT, SLTU: cout = 0, overflow = 0.
  - MUL: cout = 0; overflow = 1 when any upper-half product bit is nonzero.
- Reserved opcode 111: result = 0, zero = 1, illegal = 1, cout = 0, overflow = 0.
- Handshake:
  - A request is accepted on an edge where in_valid && in_ready.
  - in_ready = !rst && state==IDLE && (!out_valid || out_ready), i.e. a new result may be written in the same cycle the old one drains.
- States:
  - IDLE: non-MUL ops are accepted and written to the output registers on the accept edge; stay in IDLE. An accepted MUL loads the multiplicand/multiplier/accumulator, clears the counter, and goes to MUL.
  - MUL: each edge, if multiplier LSB is 1, add the shifted multiplicand into the 2·WIDTH accumulator; shift the multiplier right and the multiplicand left; increment the counter. The edge on which counter reaches WIDTH−1 writes the output registers and returns to IDLE.
- Output registers and out_valid hold unchanged while out_valid && !out_ready.
- An out_ready with out_valid=0 has no effect.

## Timing
- Reset values: result = 0, cout = 0, overflow = 0, zero = 0, illegal = 0, out_valid = 0, state = IDLE, counter = 0; in_ready = 0 while rst is high.
- Non-MUL latency: accepted on edge k → out_valid = 1 after edge k. Back-to-back throughput is 1 op/cycle when out_ready is held high.
- MUL latency: accepted on edge k → out_valid = 1 after edge k+WIDTH. in_ready = 0 after edges k … k+WIDTH−1.
- out_valid clears after the edge where out_ready=1, unless a new result is written on that same edge, in which case it stays 1.
- Reset mid-MUL: the partial product is discarded, the block goes to IDLE, and out_valid = 0 on the next cycle. No result is ever emitted for that request.
- Operand inputs are sampled only on the accept edge; changing a/b during MUL has no effect.

## Configuration
- `PIPELINED_ALU_MUL_EN` defined: the MUL state, counter, and accumulator are compiled in, with behaviour as above.
- Not defined: no multiplier logic exists. op 110 is treated as reserved: 1-cycle latency, result = 0, zero = 1, illegal = 1. The state machine never leaves IDLE.

## Test plan
- Reset release: with out_ready = 1, request ADD 40+10, cin = 0 → one cycle later result = 50, zero = 0, cout = 0, overflow = 0, illegal = 0.
- SUB 10−40 → result = 0xFFFFFFE2, cout = 0. SLT −1,1 → 1. SLTU −1,1 → 0. ADD 0x7FFFFFFF+1 → result = 0x80000000, overflow = 1.
- Backpressure: out_ready = 0, issue AND 0xF0F0,0x0FF0 → result = 0x00F0 held; in_ready = 0; a second request is not accepted. Raise out_ready → second result appears next cycle, with no drop or duplicate.
- With the macro defined, MUL 400×100 → result = 40000 after exactly 32 edges, overflow = 0. MUL 0x10000×0x10000 → result = 0, zero = 1, overflow = 1.
- Assert rst at cycle 10 of a MUL → out_valid stays 0, in_ready returns after rst drops. Next ADD 1+1 → 2.
- With the macro undefined: op 110 → 1-cycle latency, illegal = 1, result = 0. op 111 behaves the same in both builds.
